// File: rtl/isa_pkg.sv
// ---------------------------------------------------------------------------
// isa_pkg
// Shared ISA encodings for the RISC core control path.
//   - Instruction type codes, carried in inst[2:0].
//   - Function codes, carried in inst[6:3].
//   - State encoding for the register-window spill/fill sequencer.
// No ports; imported by ctrl_decode, ctrl_seq and the testbench.
// ---------------------------------------------------------------------------
package isa_pkg;

    // Instruction type codes (inst[2:0]); 3'd6 and 3'd7 are unassigned.
    localparam logic [2:0] R_TYPE = 3'd0;
    localparam logic [2:0] I_TYPE = 3'd1;
    localparam logic [2:0] B_TYPE = 3'd2;
    localparam logic [2:0] J_TYPE = 3'd3;
    localparam logic [2:0] M_TYPE = 3'd4;
    localparam logic [2:0] S_TYPE = 3'd5;

    // Function codes (inst[6:3]).
    localparam logic [3:0] JUMP  = 4'd0;
    localparam logic [3:0] LOAD  = 4'd1;
    localparam logic [3:0] STORE = 4'd2;
    localparam logic [3:0] CALL  = 4'd3;
    localparam logic [3:0] RET   = 4'd4;

    // Spill/fill sequencer states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SPILL     = 2'd1,
        FILL      = 2'd2,
        FILL_LAST = 2'd3
    } seq_state_t;

endpackage

// File: rtl/ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Purely combinational instruction decode. Outputs are ungated; the parent
// masks them with stall and inst_valid.
// Ports:
//   inst_lo   in  7  low instruction bits: type = [2:0], funct = [6:3]
//   ccr       in  4  condition-code flags
//   pc_sel, b_sel, dmem_we, wb_sel, reg_we  out  raw decode controls
//   is_call, is_ret  out  S_TYPE CALL / RET recognised
// ---------------------------------------------------------------------------
module ctrl_decode
    import isa_pkg::*;
(
    input  logic [6:0] inst_lo,
    input  logic [3:0] ccr,
    output logic       pc_sel,
    output logic       b_sel,
    output logic       dmem_we,
    output logic       wb_sel,
    output logic       reg_we,
    output logic       is_call,
    output logic       is_ret
);

    logic [2:0] inst_type;
    logic [3:0] funct;

    assign inst_type = inst_lo[2:0];
    assign funct     = inst_lo[6:3];

    always_comb begin
        pc_sel  = 1'b0;
        b_sel   = 1'b0;
        dmem_we = 1'b0;
        wb_sel  = 1'b0;
        reg_we  = 1'b0;
        is_call = 1'b0;
        is_ret  = 1'b0;
        case (inst_type)
            R_TYPE: reg_we = 1'b1;
            I_TYPE: begin
                b_sel  = 1'b1;
                reg_we = 1'b1;
            end
            // Branch: inst[4:3] selects a flag, inst[5] inverts the sense.
            B_TYPE: pc_sel = ccr[inst_lo[4:3]] ^ inst_lo[5];
            J_TYPE: begin
                if (funct == JUMP) begin
                    pc_sel = 1'b1;
                    reg_we = 1'b1;
                end
            end
            M_TYPE: begin
                if (funct == LOAD) begin
                    b_sel  = 1'b1;
                    wb_sel = 1'b1;
                    reg_we = 1'b1;
                end else if (funct == STORE) begin
                    b_sel   = 1'b1;
                    dmem_we = 1'b1;
                end
            end
            // Window instructions drive no datapath controls; only the
            // sequencer reacts to them.
            S_TYPE: begin
                is_call = (funct == CALL);
                is_ret  = (funct == RET);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ctrl_seq.sv
// ---------------------------------------------------------------------------
// ctrl_seq
// Control unit: gated instruction decode plus a register-window spill/fill
// sequencer. CALL stalls the pipeline and writes NREG registers to the stack;
// RET reads them back. Nesting is bounded by a frame counter (depth) that
// raises ovf/unf instead of starting a sequence.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   inst, inst_valid  current instruction and its valid
//   ccr               condition-code flags
//   pc_sel, b_sel, dmem_we, wb_sel, reg_we  decode controls (0 while stalled)
//   stall             sequencer busy
//   seq_rf_addr/we    register-file index / write enable for the sequencer
//   seq_mem_addr/we   stack word address / write enable
//   sp, depth         stack pointer and nesting level
//   call_done, ret_done, ovf, unf  one-cycle status pulses
// ---------------------------------------------------------------------------
module ctrl_seq
    import isa_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREG       = 16,
    parameter int SP_W       = 16,
    parameter int DEPTH      = 8,
    parameter int STACK_BASE = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [XLEN-1:0]            inst,
    input  logic                       inst_valid,
    input  logic [3:0]                 ccr,
    output logic                       pc_sel,
    output logic                       b_sel,
    output logic                       dmem_we,
    output logic                       wb_sel,
    output logic                       reg_we,
    output logic                       stall,
    output logic [$clog2(NREG)-1:0]    seq_rf_addr,
    output logic                       seq_rf_we,
    output logic [SP_W-1:0]            seq_mem_addr,
    output logic                       seq_mem_we,
    output logic [SP_W-1:0]            sp,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       call_done,
    output logic                       ret_done,
    output logic                       ovf,
    output logic                       unf
);

    localparam int SC_W    = $clog2(NREG);
    localparam int DEPTH_W = $clog2(DEPTH+1);

    localparam logic [SC_W-1:0]    SC_LAST   = SC_W'(NREG-1);
    localparam logic [SP_W-1:0]    FRAME     = SP_W'(NREG);
    localparam logic [SP_W-1:0]    SP_RESET  = SP_W'(STACK_BASE);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(DEPTH);

    seq_state_t      state;
    logic [SC_W-1:0] sc;
    logic [SC_W-1:0] sc_next;
    logic [SP_W-1:0] sp_pop;

    logic dec_pc_sel, dec_b_sel, dec_dmem_we, dec_wb_sel, dec_reg_we;
    logic dec_call, dec_ret;
    logic dec_gate;

    // Only the low seven bits carry type/funct; the rest belong to the
    // datapath (register fields, immediates).
    logic unused_inst_hi;
    assign unused_inst_hi = ^inst[XLEN-1:7];

    ctrl_decode u_decode (
        .inst_lo (inst[6:0]),
        .ccr     (ccr),
        .pc_sel  (dec_pc_sel),
        .b_sel   (dec_b_sel),
        .dmem_we (dec_dmem_we),
        .wb_sel  (dec_wb_sel),
        .reg_we  (dec_reg_we),
        .is_call (dec_call),
        .is_ret  (dec_ret)
    );

    // While the sequencer owns the register file and memory port, the
    // instruction in decode must not side-effect anything.
    assign dec_gate = inst_valid & ~stall;
    assign pc_sel   = dec_pc_sel  & dec_gate;
    assign b_sel    = dec_b_sel   & dec_gate;
    assign dmem_we  = dec_dmem_we & dec_gate;
    assign wb_sel   = dec_wb_sel  & dec_gate;
    assign reg_we   = dec_reg_we  & dec_gate;

    assign sc_next = sc + SC_W'(1);
    assign sp_pop  = sp - FRAME;

    // Sequencer. All outputs are registered so each one reflects the step
    // the FSM is in. On RET, sp is lowered on entry so the fill addresses
    // are sp+sc just like the spill; the register-file write trails the
    // memory address by one cycle to cover the read latency, which is why
    // FILL_LAST exists.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sc           <= '0;
            sp           <= SP_RESET;
            depth        <= '0;
            stall        <= 1'b0;
            seq_rf_addr  <= '0;
            seq_rf_we    <= 1'b0;
            seq_mem_addr <= '0;
            seq_mem_we   <= 1'b0;
            call_done    <= 1'b0;
            ret_done     <= 1'b0;
            ovf          <= 1'b0;
            unf          <= 1'b0;
        end else begin
            call_done <= 1'b0;
            ret_done  <= 1'b0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
            case (state)
                IDLE: begin
                    if (inst_valid && dec_call) begin
                        if (depth == DEPTH_MAX) begin
                            ovf <= 1'b1;
                        end else begin
                            state        <= SPILL;
                            sc           <= '0;
                            stall        <= 1'b1;
                            seq_mem_we   <= 1'b1;
                            seq_mem_addr <= sp;
                            seq_rf_addr  <= '0;
                        end
                    end else if (inst_valid && dec_ret) begin
                        if (depth == '0) begin
                            unf <= 1'b1;
                        end else begin
                            state        <= FILL;
                            sc           <= '0;
                            sp           <= sp_pop;
                            stall        <= 1'b1;
                            seq_rf_we    <= 1'b0;
                            seq_mem_addr <= sp_pop;
                        end
                    end
                end
                SPILL: begin
                    if (sc == SC_LAST) begin
                        state      <= IDLE;
                        sc         <= '0;
                        stall      <= 1'b0;
                        seq_mem_we <= 1'b0;
                        sp         <= sp + FRAME;
                        depth      <= depth + DEPTH_W'(1);
                    end else begin
                        sc           <= sc_next;
                        seq_rf_addr  <= sc_next;
                        seq_mem_addr <= sp + SP_W'(sc_next);
                        call_done    <= (sc_next == SC_LAST);
                    end
                end
                FILL: begin
                    seq_rf_we   <= 1'b1;
                    seq_rf_addr <= sc;
                    if (sc == SC_LAST) begin
                        state    <= FILL_LAST;
                        sc       <= '0;
                        ret_done <= 1'b1;
                    end else begin
                        sc           <= sc_next;
                        seq_mem_addr <= sp + SP_W'(sc_next);
                    end
                end
                FILL_LAST: begin
                    state     <= IDLE;
                    stall     <= 1'b0;
                    seq_rf_we <= 1'b0;
                    depth     <= depth - DEPTH_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ctrl_seq.md
# ctrl_seq

Parametrised control unit for the RISC core: combinational decode of the current instruction plus a register-window spill/fill sequencer for CALL/RET. On CALL it stalls the pipeline and streams NREG register-file entries to the data-memory stack. On RET it streams them back. A frame counter with overflow/underflow detection replaces the earlier fixed 16-step state_mode scheme. It sits between the fetch/decode stage and the register file / data-memory port mux.

## Interface
- XLEN, 32: instruction width.
- NREG, 16: registers saved per frame, at least 2.
- SP_W, 16: stack-pointer and word-address width.
- DEPTH, 8: maximum nested frames.
- STACK_BASE, 0: stack-pointer reset value (word address).

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- inst  in  XLEN  current instruction; type = inst[2:0], funct = inst[6:3].
- inst_valid  in  1  inst is valid this cycle.
- ccr  in  4  condition-code flags.
- pc_sel, b_sel, dmem_we, wb_sel, reg_we  out  1 each  decode controls.
- stall  out  1  high while the sequencer is not IDLE.
- seq_rf_addr  out  clog2(NREG)  register index being read or written by the sequencer.
- seq_rf_we  out  1  sequencer writes to the register file.
- seq_mem_addr  out  SP_W  stack word address.
- seq_mem_we  out  1  stack write.
- sp  out  SP_W  current stack pointer.
- depth  out  clog2(DEPTH+1)  current nesting level.
- call_done, ret_done  out  1  one-cycle pulses on completion.
- ovf, unf  out  1  one-cycle error pulses.

## Operation
Decode is combinational from inst. All decode outputs are 0 when stall=1, when inst_valid=0, or when the type is unknown.
- R_TYPE: reg_we=1.
- I_TYPE: b_sel=1, reg_we=1.
- B_TYPE: pc_sel = ccr[inst[4:3]] ^ inst[5].
- J_TYPE/JUMP: pc_sel=1, reg_we=1 (link).
- M_TYPE/LOAD: b_sel=1, wb_sel=1, reg_we=1.
- M_TYPE/STORE: b_sel=1, dmem_we=1.
- S_TYPE: no decode outputs. CALL and RET are handled by the FSM.

FSM states: IDLE, SPILL, FILL, FILL_LAST. Step counter sc has width clog2(NREG).
- **IDLE, CALL accepted** (inst_valid, S_TYPE/CALL):
  - If depth==DEPTH: ovf pulses, state stays IDLE.
  - Otherwise: go to SPILL with sc=0.
- **SPILL:** each cycle drives seq_mem_we=1, seq_rf_addr=sc, seq_mem_addr=sp+sc, then sc increments.
  - At sc==NREG-1: sp += NREG, depth++, call_done pulses, go to IDLE.
- **IDLE, RET accepted** (inst_valid, S_TYPE/RET):
  - If depth==0: unf pulses, state stays IDLE.
  - Otherwise: sp -= NREG at entry, go to FILL with sc=0.
- **FILL:** each cycle drives seq_mem_addr=sp+sc (read).
  - The memory read has 1-cycle latency, so seq_rf_we and seq_rf_addr are the previous cycle's sc, registered.
  - After sc==NREG-1, go to FILL_LAST.
- **FILL_LAST:** performs the final register write, then depth--, ret_done pulses, go to IDLE.
- sp arithmetic wraps modulo 2^SP_W. Overflow is guarded only by depth, never by sp.
- Instructions presented while stall=1 are ignored. Upstream holds inst until stall falls.

## Timing
- **Reset** (async assert, sync deassert by clk): state=IDLE, sc=0, sp=STACK_BASE, depth=0. stall, seq_*_we, call_done, ret_done, ovf and unf are all 0.
- **Reset mid-sequence:** the sequence aborts immediately. No partial sp or depth update survives.
- **stall** is registered. It rises the cycle after CALL/RET is accepted.
- **CALL latency:** NREG cycles of stall. call_done is asserted on the last SPILL cycle.
- **RET latency:** NREG+1 cycles of stall. ret_done is asserted in FILL_LAST.
- **ovf/unf** pulse in the cycle after the offending instruction, with no stall.
- A CALL arriving in the cycle stall falls is accepted normally, giving back-to-back sequences.

## Structure
- Shared package `isa_pkg` holds:
  - the type codes (R_TYPE, I_TYPE, B_TYPE, J_TYPE, M_TYPE, S_TYPE);
  - the funct codes (JUMP, LOAD, STORE, CALL, RET);
  - the FSM state enum.
- Sub-module `ctrl_decode`: the purely combinational decode. ctrl_seq instantiates it and gates its outputs with stall and inst_valid.

## Test plan
- **Reset:** assert rst_n=0 mid-SPILL (sc=5) -> all outputs return to reset values asynchronously; sp=STACK_BASE, depth=0.
- **Decode sweep:** each type/funct with ccr=4'b0001 -> expected control vector. For B_TYPE with inst[5:3]=3'b000, pc_sel=1; with inst[5:3]=3'b100, pc_sel=0.
- **CALL with NREG=16, sp=0:**
  - Expect 16 stall cycles with seq_mem_addr 0..15 and seq_mem_we=1.
  - Then sp=16, depth=1, call_done asserted on cycle 16.
- **RET after that CALL:**
  - Expect 17 stall cycles with seq_mem_addr 0..15.
  - seq_rf_we asserted on cycles 2..17 with seq_rf_addr 0..15.
  - Then sp=0, depth=0. A memory model returning data=addr yields register r == r.
- **Boundaries:**
  - DEPTH+1 nested CALLs -> last gives ovf=1, no stall, depth=DEPTH.
  - RET at depth 0 -> unf=1, sp unchanged.
- **Back-to-back:** CALL presented while stall=1 is ignored. The same CALL held until stall falls is accepted -> depth=2.
